// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// One memory-request channel: request/address handshake, write-beat
// handshake and the read-response path. The same bundle describes both a
// cache-facing port and the memory-facing port, because the signal set is
// identical on both sides of the arbiter.
//
// Modports
//   master : the requester (a cache, or the arbiter toward memory).
//            Drives req_val/req_rw/req_addr and the write-beat fields;
//            receives req_rdy, req_data_ready and the response.
//   slave  : the responder (the arbiter toward a cache, or memory).
//
// Signals
//   req_val / req_rdy            request handshake
//   req_rw                       1 = write, 0 = read
//   req_addr                     line/chunk address
//   req_data_valid / _ready      write-beat handshake
//   req_data_bits/_mask/_offset  write beat payload, byte mask, beat offset
//   resp_val                     read data beat valid
//   resp_nack                    request refused, must be re-issued
//   resp_data                    read data beat
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128
);
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_rw;
    logic [ADDR_BITS-1:0]   req_addr;
    logic                   req_data_valid;
    logic                   req_data_ready;
    logic [DATA_BITS-1:0]   req_data_bits;
    logic [DATA_BITS/8-1:0] req_data_mask;
    logic [1:0]             req_data_offset;
    logic                   resp_val;
    logic                   resp_nack;
    logic [DATA_BITS-1:0]   resp_data;

    modport master (
        output req_val, req_rw, req_addr,
        output req_data_valid, req_data_bits, req_data_mask, req_data_offset,
        input  req_rdy, req_data_ready,
        input  resp_val, resp_nack, resp_data
    );

    modport slave (
        input  req_val, req_rw, req_addr,
        input  req_data_valid, req_data_bits, req_data_mask, req_data_offset,
        output req_rdy, req_data_ready,
        output resp_val, resp_nack, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one memory channel between two caches (p0 = icache, p1 = dcache).
// A single transaction is in flight at a time:
//   IDLE       : combinational round-robin grant, granted port mirrored to
//                memory. A write whose first beat is handshaken together
//                with the request completes without leaving IDLE.
//   READ_WAIT  : response beats routed to the owner only; the last beat
//                (REFILL_BEATS-1) returns to IDLE. A nack goes to NACK_LOCK.
//   WRITE_DATA : owner's write beat forwarded until it is handshaken.
//   NACK_LOCK  : only the nacked owner may re-issue, so the refused request
//                is retried before anything from the other port.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   p0, p1   (slave)    cache-side channels
//   mem      (master)   memory-side channel
//
// Parameters
//   ADDR_BITS      address width
//   DATA_BITS      beat width (mask is DATA_BITS/8 bits)
//   REFILL_BEATS   response beats per read
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_BITS    = 28,
    parameter int DATA_BITS    = 128,
    parameter int REFILL_BEATS = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  p0,
    mem_arbiter_if.slave  p1,
    mem_arbiter_if.master mem
);

    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int CNT_W     = (REFILL_BEATS > 1) ? $clog2(REFILL_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(REFILL_BEATS - 1);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] READ_WAIT  = 2'd1;
    localparam logic [1:0] WRITE_DATA = 2'd2;
    localparam logic [1:0] NACK_LOCK  = 2'd3;

    logic [1:0]       state;
    logic             owner;
    logic             rr;
    logic [CNT_W-1:0] beat_cnt;

    // Both cache ports flattened into arrays so one select bit picks a port.
    logic [1:0]           port_val;
    logic [1:0]           port_rw;
    logic [1:0]           port_dvalid;
    logic [ADDR_BITS-1:0] port_addr [2];
    logic [DATA_BITS-1:0] port_bits [2];
    logic [MASK_BITS-1:0] port_mask [2];
    logic [1:0]           port_off  [2];

    assign port_val    = {p1.req_val,        p0.req_val};
    assign port_rw     = {p1.req_rw,         p0.req_rw};
    assign port_dvalid = {p1.req_data_valid, p0.req_data_valid};
    assign port_addr[0] = p0.req_addr;
    assign port_addr[1] = p1.req_addr;
    assign port_bits[0] = p0.req_data_bits;
    assign port_bits[1] = p1.req_data_bits;
    assign port_mask[0] = p0.req_data_mask;
    assign port_mask[1] = p1.req_data_mask;
    assign port_off[0]  = p0.req_data_offset;
    assign port_off[1]  = p1.req_data_offset;

    logic idle_grant;
    logic fwd_en;
    logic sel;
    logic req_accept;
    logic data_path;
    logic data_hs;
    logic in_read;

    // A lone requester wins outright; a tie goes to the port rr points at.
    always_comb begin
        case (port_val)
            2'b01:   idle_grant = 1'b0;
            2'b10:   idle_grant = 1'b1;
            default: idle_grant = rr;
        endcase
    end

    // Requests reach memory only in IDLE and NACK_LOCK. In NACK_LOCK and in
    // the transfer states the selected port is the owner, so rr is ignored.
    assign fwd_en = (state == IDLE) || (state == NACK_LOCK);
    assign sel    = (state == IDLE) ? idle_grant : owner;

    assign mem.req_val  = ~reset & fwd_en & port_val[sel];
    assign mem.req_rw   = port_rw[sel];
    assign mem.req_addr = port_addr[sel];

    assign req_accept = mem.req_val & mem.req_rdy;

    // The write-beat path is open in WRITE_DATA, and also alongside a write
    // request that is being accepted this very cycle. Qualifying the
    // early beat with mem.req_rdy keeps a beat from being consumed for a
    // request that memory has not taken.
    assign data_path = (state == WRITE_DATA) |
                       (fwd_en & port_val[sel] & port_rw[sel] & mem.req_rdy);

    assign mem.req_data_valid  = ~reset & data_path & port_dvalid[sel];
    assign mem.req_data_bits   = port_bits[sel];
    assign mem.req_data_mask   = port_mask[sel];
    assign mem.req_data_offset = port_off[sel];

    assign data_hs = mem.req_data_valid & mem.req_data_ready;

    assign p0.req_rdy = ~reset & fwd_en & ~sel & mem.req_rdy;
    assign p1.req_rdy = ~reset & fwd_en &  sel & mem.req_rdy;

    assign p0.req_data_ready = ~reset & data_path & ~sel & mem.req_data_ready;
    assign p1.req_data_ready = ~reset & data_path &  sel & mem.req_data_ready;

    // Responses are only meaningful while a read is outstanding; anything
    // memory presents in other states is dropped. A beat that arrives
    // together with a nack is taken as data.
    assign in_read = ~reset & (state == READ_WAIT);

    assign p0.resp_val  = in_read & ~owner & mem.resp_val;
    assign p1.resp_val  = in_read &  owner & mem.resp_val;
    assign p0.resp_nack = in_read & ~owner & mem.resp_nack & ~mem.resp_val;
    assign p1.resp_nack = in_read &  owner & mem.resp_nack & ~mem.resp_val;

    // Read data is broadcast; resp_val alone tells a cache the beat is its.
    assign p0.resp_data = mem.resp_data;
    assign p1.resp_data = mem.resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            rr       <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE, NACK_LOCK: begin
                    if (req_accept) begin
                        owner    <= sel;
                        rr       <= ~sel;
                        beat_cnt <= '0;
                        if (!port_rw[sel]) begin
                            state <= READ_WAIT;
                        end else if (data_hs) begin
                            state <= IDLE;
                        end else begin
                            state <= WRITE_DATA;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem.resp_val) begin
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (mem.resp_nack) begin
                        state    <= NACK_LOCK;
                        beat_cnt <= '0;
                    end
                end
                WRITE_DATA: begin
                    if (data_hs) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed stimulus for mem_arbiter. Each expected DUT event (request
// acceptance, write-beat handshake, response beat, nack) is queued when the
// stimulus that causes it is driven; a negedge monitor pops and compares
// every event the DUT actually presents. Cycle-specific properties (reset
// outputs, held state, grant direction) are compared directly.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    localparam int AB = 28;
    localparam int DB = 128;
    localparam int MB = DB / 8;
    localparam int RB = 4;

    localparam int K_ACC  = 0;
    localparam int K_WD   = 1;
    localparam int K_RESP = 2;
    localparam int K_NACK = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) p0_if();
    mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) p1_if();
    mem_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) mem_if();

    mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .REFILL_BEATS(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .p0    (p0_if),
        .p1    (p1_if),
        .mem   (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;
        int           port;
        logic [159:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    function automatic logic [159:0] mk_acc(input logic rw, input logic [AB-1:0] a);
        return {131'd0, rw, a};
    endfunction

    function automatic logic [159:0] mk_wd(input logic [1:0] o, input logic [MB-1:0] m,
                                           input logic [DB-1:0] b);
        return {14'd0, o, m, b};
    endfunction

    function automatic logic [159:0] mk_resp(input logic [DB-1:0] d);
        return {32'd0, d};
    endfunction

    task automatic push(input int kind, input int port, input logic [159:0] val);
        ev_t e;
        e.kind = kind;
        e.port = port;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input int kind, input int port, input logic [159:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d port=%0d val=%h, required no event",
                     kind, port, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.port != port || e.val !== val) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d port=%0d val=%h, required kind=%0d port=%0d val=%h",
                         kind, port, val, e.kind, e.port, e.val);
            end
        end
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every DUT output event is matched against the queue.
    always @(negedge clk) begin
        if (mem_if.req_val && mem_if.req_rdy)
            sb_check(K_ACC, p1_if.req_rdy ? 1 : 0, mk_acc(mem_if.req_rw, mem_if.req_addr));
        if (mem_if.req_data_valid && mem_if.req_data_ready)
            sb_check(K_WD, p1_if.req_data_ready ? 1 : 0,
                     mk_wd(mem_if.req_data_offset, mem_if.req_data_mask, mem_if.req_data_bits));
        if (p0_if.resp_val) sb_check(K_RESP, 0, mk_resp(p0_if.resp_data));
        if (p1_if.resp_val) sb_check(K_RESP, 1, mk_resp(p1_if.resp_data));
        if (p0_if.resp_nack) sb_check(K_NACK, 0, 160'd0);
        if (p1_if.resp_nack) sb_check(K_NACK, 1, 160'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        p0_if.req_val = 0; p0_if.req_rw = 0; p0_if.req_addr = '0;
        p0_if.req_data_valid = 0; p0_if.req_data_bits = '0;
        p0_if.req_data_mask = '0; p0_if.req_data_offset = '0;
        p1_if.req_val = 0; p1_if.req_rw = 0; p1_if.req_addr = '0;
        p1_if.req_data_valid = 0; p1_if.req_data_bits = '0;
        p1_if.req_data_mask = '0; p1_if.req_data_offset = '0;
        mem_if.req_rdy = 0; mem_if.req_data_ready = 0;
        mem_if.resp_val = 0; mem_if.resp_nack = 0; mem_if.resp_data = '0;
    endtask

    task automatic req(input int port, input logic v, input logic rw, input logic [AB-1:0] a);
        if (port == 0) begin
            p0_if.req_val = v; p0_if.req_rw = rw; p0_if.req_addr = a;
        end else begin
            p1_if.req_val = v; p1_if.req_rw = rw; p1_if.req_addr = a;
        end
    endtask

    task automatic wdata(input int port, input logic v, input logic [DB-1:0] b,
                         input logic [MB-1:0] m, input logic [1:0] o);
        if (port == 0) begin
            p0_if.req_data_valid = v; p0_if.req_data_bits = b;
            p0_if.req_data_mask = m;  p0_if.req_data_offset = o;
        end else begin
            p1_if.req_data_valid = v; p1_if.req_data_bits = b;
            p1_if.req_data_mask = m;  p1_if.req_data_offset = o;
        end
    endtask

    // Deliver a full refill; optionally raise nack alongside the first beat.
    task automatic serve(input int port, input logic [DB-1:0] base, input logic nack_first);
        for (int b = 0; b < RB; b++) begin
            mem_if.resp_val  = 1;
            mem_if.resp_nack = (b == 0) && nack_first;
            mem_if.resp_data = base + DB'(b);
            push(K_RESP, port, mk_resp(base + DB'(b)));
            tick();
        end
        mem_if.resp_val  = 0;
        mem_if.resp_nack = 0;
    endtask

    localparam logic [DB-1:0] D_A = 128'hA000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [DB-1:0] D_B = 128'hB111_2222_3333_4444_5555_6666_7777_0000;
    localparam logic [DB-1:0] D_C = 128'hC0DE_0000_1234_5678_9ABC_DEF0_0000_0000;
    localparam logic [DB-1:0] D_D = 128'hD00D_FEED_0000_0000_0000_0000_0000_0000;
    localparam logic [DB-1:0] W_1 = 128'hFACE_CAFE_0123_4567_89AB_CDEF_5555_AAAA;
    localparam logic [DB-1:0] W_2 = 128'h1234_0000_5678_0000_9ABC_0000_DEF0_0000;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle_all();
        reset = 1;
        repeat (3) tick();

        // Reset cycle: every handshake output low despite active inputs.
        p0_if.req_val = 1; p0_if.req_rw = 1; p0_if.req_data_valid = 1;
        p1_if.req_val = 1;
        mem_if.req_rdy = 1; mem_if.req_data_ready = 1;
        mem_if.resp_val = 1; mem_if.resp_nack = 1;
        settle();
        chk("rst_mem_req_val",    160'(mem_if.req_val),        160'(0));
        chk("rst_p0_req_rdy",     160'(p0_if.req_rdy),         160'(0));
        chk("rst_p1_req_rdy",     160'(p1_if.req_rdy),         160'(0));
        chk("rst_mem_data_valid", 160'(mem_if.req_data_valid), 160'(0));
        chk("rst_p0_data_ready",  160'(p0_if.req_data_ready),  160'(0));
        chk("rst_resp_val",       160'({p1_if.resp_val, p0_if.resp_val}),   160'(0));
        chk("rst_resp_nack",      160'({p1_if.resp_nack, p0_if.resp_nack}), 160'(0));
        idle_all();
        reset = 0;

        // Both read: p0 first (rr=0), four beats to p0 only, then p1.
        req(0, 1, 0, 28'h10);
        req(1, 1, 0, 28'h20);
        mem_if.req_rdy = 1;
        push(K_ACC, 0, mk_acc(0, 28'h10));
        tick();
        req(0, 0, 0, 28'h10);
        settle();
        chk("rd_wait_no_req_val", 160'(mem_if.req_val), 160'(0));
        chk("rd_wait_p1_no_rdy",  160'(p1_if.req_rdy),  160'(0));
        serve(0, D_A, 0);
        push(K_ACC, 1, mk_acc(0, 28'h20));
        tick();
        req(1, 0, 0, 28'h20);
        serve(1, D_B, 0);

        // p1 read nacked after two idle cycles while p0 waits.
        req(1, 1, 0, 28'h30);
        push(K_ACC, 1, mk_acc(0, 28'h30));
        tick();
        req(1, 0, 0, 28'h30);
        req(0, 1, 0, 28'h40);
        tick();
        tick();
        mem_if.resp_nack = 1;
        push(K_NACK, 1, 160'd0);
        tick();
        mem_if.resp_nack = 0;
        settle();
        chk("nlock_p0_blocked",  160'(mem_if.req_val), 160'(0));
        chk("nlock_p0_no_rdy",   160'(p0_if.req_rdy),  160'(0));
        req(1, 1, 0, 28'h30);
        settle();
        chk("nlock_owner_addr",  160'(mem_if.req_addr), 160'(28'h30));
        push(K_ACC, 1, mk_acc(0, 28'h30));
        tick();
        req(1, 0, 0, 28'h30);
        serve(1, D_C, 0);
        push(K_ACC, 0, mk_acc(0, 28'h40));
        tick();
        req(0, 0, 0, 28'h40);
        serve(0, D_D, 0);

        // Stray response in IDLE is dropped.
        mem_if.resp_val = 1;
        mem_if.resp_data = D_A;
        settle();
        chk("idle_drop_resp", 160'({p1_if.resp_val, p0_if.resp_val}), 160'(0));
        tick();
        mem_if.resp_val = 0;

        // p1 write held for three cycles with data ready low.
        req(1, 1, 1, 28'h50);
        wdata(1, 1, W_1, 16'hF00F, 2'd2);
        mem_if.req_rdy = 1;
        mem_if.req_data_ready = 0;
        push(K_ACC, 1, mk_acc(1, 28'h50));
        tick();
        req(1, 0, 1, 28'h50);
        for (int c = 0; c < 2; c++) begin
            settle();
            chk("wr_hold_valid",  160'(mem_if.req_data_valid),  160'(1));
            chk("wr_hold_mask",   160'(mem_if.req_data_mask),   160'(16'hF00F));
            chk("wr_hold_offset", 160'(mem_if.req_data_offset), 160'(2));
            chk("wr_hold_rdy",    160'(p1_if.req_data_ready),   160'(0));
            tick();
        end
        mem_if.req_data_ready = 1;
        push(K_WD, 1, mk_wd(2'd2, 16'hF00F, W_1));
        settle();
        chk("wr_p1_data_ready", 160'(p1_if.req_data_ready), 160'(1));
        chk("wr_p0_data_ready", 160'(p0_if.req_data_ready), 160'(0));
        tick();
        wdata(1, 0, '0, '0, 2'd0);

        // p0 write with the beat handshaken alongside the request.
        req(0, 1, 1, 28'h60);
        wdata(0, 1, W_2, 16'h00FF, 2'd1);
        push(K_ACC, 0, mk_acc(1, 28'h60));
        push(K_WD, 0, mk_wd(2'd1, 16'h00FF, W_2));
        tick();
        req(0, 0, 0, 28'h60);
        wdata(0, 0, '0, '0, 2'd0);
        mem_if.req_data_ready = 0;

        // Immediate read proves IDLE; first beat carries nack too.
        req(1, 1, 0, 28'h70);
        push(K_ACC, 1, mk_acc(0, 28'h70));
        tick();
        req(1, 0, 0, 28'h70);
        serve(1, D_B, 1);

        // Reset after two beats of a p0 read.
        req(0, 1, 0, 28'h80);
        push(K_ACC, 0, mk_acc(0, 28'h80));
        tick();
        req(0, 0, 0, 28'h80);
        for (int b = 0; b < 2; b++) begin
            mem_if.resp_val = 1;
            mem_if.resp_data = D_C + DB'(b);
            push(K_RESP, 0, mk_resp(D_C + DB'(b)));
            tick();
        end
        reset = 1;
        mem_if.resp_data = D_C + DB'(2);
        settle();
        chk("midrd_rst_resp", 160'(p0_if.resp_val), 160'(0));
        tick();
        reset = 0;
        for (int b = 2; b < 4; b++) begin
            mem_if.resp_data = D_C + DB'(b);
            settle();
            chk("post_rst_resp", 160'({p1_if.resp_val, p0_if.resp_val}), 160'(0));
            tick();
        end
        mem_if.resp_val = 0;

        // rr back to p0 after reset.
        req(0, 1, 0, 28'h90);
        req(1, 1, 0, 28'hA0);
        push(K_ACC, 0, mk_acc(0, 28'h90));
        tick();
        req(0, 0, 0, 28'h90);
        serve(0, D_D, 0);

        // Memory stalls five cycles, both requesting: grant stays on p1.
        req(0, 1, 0, 28'h90);
        mem_if.req_rdy = 0;
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("stall_req_val", 160'(mem_if.req_val),  160'(1));
            chk("stall_addr",    160'(mem_if.req_addr), 160'(28'hA0));
            chk("stall_rdys",    160'({p1_if.req_rdy, p0_if.req_rdy}), 160'(0));
            tick();
        end
        mem_if.req_rdy = 1;
        push(K_ACC, 1, mk_acc(0, 28'hA0));
        tick();
        req(1, 0, 0, 28'hA0);
        serve(1, D_A, 0);
        push(K_ACC, 0, mk_acc(0, 28'h90));
        tick();
        req(0, 0, 0, 28'h90);
        serve(0, D_B, 0);

        idle_all();
        tick();
        tick();
        chk("sb_queue_empty", 160'(exp_q.size()), 160'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 28: memory line/chunk address width, matching the cache mem_req_addr.
REQ-002 The block SHALL have parameter DATA_BITS, default 128: memory beat width.
REQ-003 The block SHALL have parameter REFILL_BEATS, default 4: response beats per read.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state updated on rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-006 The block SHALL have ports p0_/p1_ req_val, req_rw, req_data_valid, each input, 1 bit: per-cache request, write flag, write-beat valid (p0 = icache, p1 = dcache).
REQ-007 The block SHALL have ports p0_/p1_ req_rdy, req_data_ready, each output, 1 bit: request and write-beat accepted.
REQ-008 The block SHALL have ports p0_/p1_ req_addr input ADDR_BITS, req_data_bits input DATA_BITS, req_data_mask input DATA_BITS/8, req_data_offset input 2.
REQ-009 The block SHALL have ports p0_/p1_ resp_val, resp_nack, each output, 1 bit, and p0_/p1_ resp_data, output, DATA_BITS: routed memory response.
REQ-010 The block SHALL have memory-side ports mem_req_val out 1, mem_req_rdy in 1, mem_req_addr out ADDR_BITS, mem_req_rw out 1.
REQ-011 The block SHALL have memory-side ports mem_req_data_valid out 1, mem_req_data_ready in 1, mem_req_data_bits out DATA_BITS, mem_req_data_mask out DATA_BITS/8, mem_req_data_offset out 2.
REQ-012 The block SHALL have memory-side ports mem_resp_val in 1, mem_resp_nack in 1, mem_resp_data in DATA_BITS.

Function
REQ-013 States SHALL be IDLE, READ_WAIT, WRITE_DATA, NACK_LOCK; a 1-bit owner register and a 1-bit round-robin pointer rr SHALL be kept.
REQ-014 In IDLE, the grant SHALL be combinational: if exactly one port has req_val it wins; if both do, the port selected by rr wins.
REQ-015 In IDLE, mem_req_* SHALL mirror the granted port; the granted port's req_rdy SHALL equal mem_req_rdy; the loser's req_rdy SHALL be 0.
REQ-016 On acceptance (mem_req_val & mem_req_rdy), owner SHALL be set to the granted port and rr SHALL point to the other port.
REQ-017 A read acceptance (rw=0) SHALL move to READ_WAIT with beat counter = 0.
REQ-018 A write acceptance (rw=1) SHALL move to WRITE_DATA; if data_valid & mem_req_data_ready hold in the same cycle, the state SHALL return to IDLE instead.
REQ-019 In READ_WAIT, mem_resp_val SHALL drive only owner's resp_val (resp_data broadcast to both ports); the counter SHALL increment per beat; the beat with counter = REFILL_BEATS-1 SHALL return the state to IDLE.
REQ-020 In READ_WAIT, mem_resp_nack SHALL pulse owner's resp_nack and move to NACK_LOCK; the counter SHALL be cleared.
REQ-021 In NACK_LOCK, only owner SHALL be forwarded to memory, regardless of rr; its re-acceptance SHALL move to READ_WAIT (read) or WRITE_DATA (write).
REQ-022 In WRITE_DATA, owner's data_valid/bits/mask/offset SHALL be forwarded; owner's req_data_ready SHALL equal mem_req_data_ready; a data handshake SHALL return the state to IDLE.
REQ-023 Outside IDLE/NACK_LOCK, mem_req_val and both req_rdy SHALL be 0; a non-owner SHALL never see resp_val, resp_nack or req_data_ready.
REQ-024 Simultaneous mem_resp_val and mem_resp_nack SHALL be treated as resp_val (nack ignored).
REQ-025 mem_resp_val in IDLE or WRITE_DATA SHALL be dropped; no output SHALL assert.

Reset
REQ-026 Reset SHALL force IDLE, rr = 0 (p0 preferred), owner = 0, counter = 0, including mid-read or mid-write; all handshake outputs SHALL be 0 in the reset cycle.

Verification
REQ-027 Both ports request reads at A=0x10 (p0), 0x20 (p1) with mem_req_rdy=1 after reset -> p0 granted first, 4 beats to p0 only, then p1 granted.
REQ-028 p1 read accepted, mem returns nack after 2 idle cycles, p0 requests meanwhile -> p1_resp_nack pulse, p1 re-request granted before p0.
REQ-029 p1 write with data_valid, mem_req_data_ready=0 for 3 cycles -> state held WRITE_DATA, mask/offset stable, p1_req_data_ready asserts on cycle 4, then IDLE.
REQ-030 Reset asserted after beat 2 of a 4-beat read -> IDLE next cycle, later beats produce no resp_val.
REQ-031 mem_req_rdy=0 for 5 cycles with both ports requesting -> no acceptance, rr unchanged, grant stays on rr port.
